fpm_seq: RTL and testbench
==========================

Name: fpm_seq

Overview:
- Parametrised, handshaked successor to the combinational fixed-point multiplier in the DSP datapath.
- Takes two sign-magnitude fixed-point operands with Q fraction bits and forms the magnitude product. It rescales the product by dropping Q bits, then divides by a decimal SCALE with round-half-up.
- Returns a saturated sign-magnitude result.
- Division is a sequential restoring divider, one quotient bit per cycle, replacing the combinational divide-by-constant. Results feed the accumulator/output stage through a valid/ready interface.

Parameters:
- N, 32: operand width; bit N-1 is sign, bits N-2:0 are magnitude.
- Q, 15: fraction bits of the operand product that are discarded (product >> Q).
- OUT_W, 11: result width; bit OUT_W-1 is sign, OUT_W-2:0 is magnitude.
- SCALE, 10000: decimal divisor. Legal range is 2 <= SCALE < 2^(N-1).

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: operands a/b are valid.
- in_ready, out, 1: block accepts operands (high only in IDLE).
- a, in, N: operand A, sign-magnitude.
- b, in, N: operand B, sign-magnitude.
- out_valid, out, 1: mul_out/ovf are valid.
- out_ready, in, 1: consumer takes the result.
- mul_out, out, OUT_W: rounded, scaled result, sign-magnitude.
- ovf, out, 1: result saturated; qualified by out_valid.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at an edge): state goes to IDLE. out_valid=0, mul_out=0, ovf=0, busy=0, in_ready=1 in the following cycle. Reset aborts any operation in flight with no output produced, and takes priority over all other inputs.
- States: IDLE, MUL, DIV, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, register sgn=a[N-1]^b[N-1], ma=a[N-2:0], mb=b[N-2:0], then go to MUL.
  - in_valid in any other state is ignored; operands are not sampled.
- MUL (1 cycle):
  - P=ma*mb at full 2N-2 bits. M=P>>Q.
  - If M >= 2^(N-1), clamp M to 2^(N-1)-1 and set the internal sticky flag pre_ovf.
  - Load dividend M, remainder 0, and iteration count N-1, then go to DIV.
- DIV (N-1 cycles):
  - Each cycle is one restoring step: shift the remainder left and bring in the next dividend MSB. If rem >= SCALE, subtract SCALE and set the quotient bit to 1.
  - After N-1 steps, go to ROUND.
- ROUND (1 cycle):
  - If 2*rem >= SCALE, then q=q+1 (round half up on the magnitude, i.e. half away from zero).
  - If q > 2^(OUT_W-1)-1, or pre_ovf is set, the magnitude becomes 2^(OUT_W-1)-1 and ovf=1.
  - If the final magnitude is 0, the sign is forced to 0 (no negative zero).
  - Register mul_out={sign,magnitude} and go to DONE.
- DONE:
  - out_valid=1. mul_out and ovf are held stable while out_ready=0.
  - On out_ready=1, return to IDLE; out_valid drops at that edge.
- Latency:
  - The accepting edge is E0. out_valid goes high after edge E0+N+1, i.e. 33 cycles for N=32.
  - Minimum initiation interval is N+3 cycles: no accept in DONE, and in_ready returns the cycle after the result is taken.
- Widths:
  - Remainder register needs width ceil(log2(SCALE))+1.
  - Quotient register is N-1 bits, with one extra bit for the rounding carry.
- mul_out/ovf outside DONE: hold their last value; they are not guaranteed meaningful.

Test Plan:
- a=98304 (3.0), b=50000 -> M=150000, q=15 r0. After 33 cycles: mul_out=15, ovf=0.
- Rounding boundary:
  - a=32768, b=25000 -> r=5000, mul_out=3.
  - a=32768, b=24999 -> mul_out=2.
- Sign and negative zero:
  - a=0x80008000, b=25000 -> mul_out=0x403.
  - a=0x80008000, b=4999 -> mul_out=0 (sign cleared).
  - a=0x80008000, b=0x80000000|25000 -> mul_out=3.
- Saturation:
  - a=32768, b=10235000 -> rounded q=1024 -> mul_out=1023, ovf=1.
  - a=0x7FFFFFFF, b=0x7FFFFFFF -> M clamped -> mul_out=1023, ovf=1.
- Handshake:
  - Hold out_ready=0 for 10 cycles in DONE -> mul_out stable, in_ready=0.
  - Pulse in_valid during DIV with different operands -> ignored, result unchanged.
  - Assert out_ready -> in_ready=1 next cycle. Run back-to-back ops; each takes N+3 cycles.
- Reset mid-operation:
  - Assert rst for 1 cycle in DIV (cycle 10) -> next cycle IDLE, out_valid=0, mul_out=0, busy=0.
  - A fresh op then yields the correct result with no stale remainder.

Source files
------------

// File: rtl/fpm_seq.sv
// fpm_seq: sign-magnitude fixed-point multiply, rescale by Q bits, then divide
// by a decimal SCALE with round-half-up. A sequential restoring divider produces
// one quotient bit per cycle. The result leaves through a valid/ready handshake.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | in_ready high, waiting for operands
//   MUL   | magnitude product, drop Q bits, clamp, load the divider
//   DIV   | N-1 restoring steps, one quotient bit per cycle
//   ROUND | round half up, saturate, strip negative zero, register result
//   DONE  | out_valid high, result held until out_ready
module fpm_seq #(
  parameter int N     = 32,
  parameter int Q     = 15,
  parameter int OUT_W = 11,
  parameter int SCALE = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] mul_out,
  output logic             ovf,
  output logic             busy
);

  // The remainder stays below SCALE, so a one-bit shift fits in RW bits.
  localparam int RW   = $clog2(SCALE) + 1;
  localparam int CW   = $clog2(N);
  localparam int MAXI = (1 << (OUT_W - 1)) - 1;

  localparam logic [RW-1:0] SCALE_R = RW'(SCALE);
  localparam logic [N-1:0]  MAX_Q   = N'(MAXI);
  localparam logic [CW-1:0] ITER    = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV, ROUND, DONE} state_t;

  state_t state, state_nxt;

  logic          sgn;
  logic          pre_ovf;
  logic [N-2:0]  ma, mb;
  logic [N-2:0]  dvd;
  logic [N-2:0]  quo;
  logic [RW-1:0] rem;
  logic [CW-1:0] cnt;

  logic [2*N-3:0]   prod;
  logic [2*N-3:0]   m_full;
  logic             m_big;
  logic [N-2:0]     m_clamp;
  logic [RW:0]      rem_sh;
  logic             q_bit;
  logic             rnd;
  logic [N-1:0]     q_rnd;
  logic             sat;
  logic [OUT_W-2:0] mag;

  // Arithmetic for the multiply, divide step and rounding stages.
  always_comb begin
    prod    = {{(N-1){1'b0}}, ma} * {{(N-1){1'b0}}, mb};
    m_full  = prod >> Q;
    m_big   = |m_full[2*N-3:N-1];
    m_clamp = m_big ? '1 : m_full[N-2:0];
    rem_sh  = {rem, dvd[N-2]};
    q_bit   = rem_sh >= {1'b0, SCALE_R};
    rnd     = {rem, 1'b0} >= {1'b0, SCALE_R};
    q_rnd   = {1'b0, quo} + {{(N-1){1'b0}}, rnd};
    sat     = pre_ovf || (q_rnd > MAX_Q);
    mag     = sat ? '1 : q_rnd[OUT_W-2:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the divide loop ends on the terminal count of 1.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MUL;
      MUL:     state_nxt = DIV;
      DIV:     if (cnt == CW'(1)) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers, advanced according to the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn     <= 1'b0;
      pre_ovf <= 1'b0;
      ma      <= '0;
      mb      <= '0;
      dvd     <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
      mul_out <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sgn <= a[N-1] ^ b[N-1];
            ma  <= a[N-2:0];
            mb  <= b[N-2:0];
          end
        end
        MUL: begin
          dvd     <= m_clamp;
          pre_ovf <= m_big;
          rem     <= '0;
          quo     <= '0;
          cnt     <= ITER;
        end
        DIV: begin
          rem <= q_bit ? RW'(rem_sh - {1'b0, SCALE_R}) : rem_sh[RW-1:0];
          quo <= {quo[N-3:0], q_bit};
          dvd <= {dvd[N-3:0], 1'b0};
          cnt <= cnt - CW'(1);
        end
        ROUND: begin
          mul_out <= {sgn & (mag != '0), mag};
          ovf     <= sat;
        end
        default: ;
      endcase
    end
  end

  // Handshake and status outputs decode straight from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

endmodule

// File: tb/tb_fpm_seq.sv
// Scoreboard bench for fpm_seq: the driver pushes expected results from an
// arithmetic reference model, and a monitor pops and compares on each handshake.
module tb_fpm_seq;

  localparam int N     = 32;
  localparam int Q     = 15;
  localparam int OUT_W = 11;
  localparam int SCALE = 10000;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a, b;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] mul_out;
  logic             ovf;
  logic             busy;

  fpm_seq #(.N(N), .Q(Q), .OUT_W(OUT_W), .SCALE(SCALE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .mul_out(mul_out), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] mo;
    logic             ov;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_acc = 0;
  bit   rnd_rdy = 0;
  bit   seen = 0;
  bit   chk_rdy = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the magnitudes.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [OUT_W-1:0] mo, output logic ov);
    longint unsigned ma, mb, p, m, q, r, magv;
    bit pre;
    ma = {33'd0, x[30:0]};
    mb = {33'd0, y[30:0]};
    p  = ma * mb;
    m  = p >> Q;
    pre = (m >= (64'd1 << 31));
    if (pre) m = (64'd1 << 31) - 1;
    q = m / SCALE;
    r = m % SCALE;
    if (2 * r >= SCALE) q = q + 1;
    ov   = pre || (q > 1023);
    magv = ov ? 64'd1023 : q;
    mo   = {(x[31] ^ y[31]) && (magv != 0), magv[9:0]};
  endfunction

  // Random consumer back-pressure during the random phase.
  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency on first sight of out_valid, value on the taking edge.
  always @(negedge clk) begin
    if (rst) begin
      seen    = 0;
      chk_rdy = 0;
    end else begin
      if (chk_rdy) begin
        check("in_ready_after_take", in_ready, 1);
        check("out_valid_drop", out_valid, 0);
        chk_rdy = 0;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0h with empty scoreboard", mul_out);
        end else begin
          if (!seen) begin
            check("latency", cyc - sb[0].acc, N + 1);
            seen = 1;
          end
          if (out_ready) begin
            check("mul_out", mul_out, sb[0].mo);
            check("ovf", ovf, sb[0].ov);
            void'(sb.pop_front());
            seen    = 0;
            chk_rdy = 1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    int g;
    exp_t e;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: in_ready got 0 expected 1");
      return;
    end
    a = x;
    b = y;
    in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    model(x, y, e.mo, e.ov);
    e.acc = cyc;
    last_acc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((sb.size() != 0 || !in_ready) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("drain", sb.size(), 0);
  endtask

  logic [31:0] dir_a [8] = '{32'd98304, 32'd32768, 32'd32768, 32'h80008000,
                             32'h80008000, 32'h80008000, 32'd32768, 32'h7FFFFFFF};
  logic [31:0] dir_b [8] = '{32'd50000, 32'd25000, 32'd24999, 32'd25000,
                             32'd4999, 32'h80000000 | 32'd25000, 32'd10235000, 32'h7FFFFFFF};

  initial begin
    int prev;
    logic [OUT_W-1:0] emo;
    logic eov;
    logic [31:0] x, y;
    int g;

    rst = 1; in_valid = 0; out_ready = 1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_mul_out", mul_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // Directed vectors, back to back with the consumer always ready.
    prev = -1;
    foreach (dir_a[i]) begin
      issue(dir_a[i], dir_b[i]);
      if (prev >= 0) check("init_interval", last_acc - prev, N + 3);
      prev = last_acc;
    end
    wait_idle();

    // Result held while the consumer stalls.
    @(posedge clk); #1 out_ready = 0;
    issue(32'd98304, 32'd50000);
    model(32'd98304, 32'd50000, emo, eov);
    g = 0;
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("hold_reached_done", out_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_mul_out", mul_out, emo);
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1;
    wait_idle();

    // in_valid pulsed mid-divide must be ignored.
    issue(32'd32768, 32'd25000);
    repeat (5) @(negedge clk);
    check("div_busy", busy, 1);
    check("div_in_ready", in_ready, 0);
    a = 32'h7FFFFFFF; b = 32'h7FFFFFFF; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    wait_idle();

    // Reset in the middle of the divide, then a clean operation.
    issue(32'd98304, 32'd50000);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    @(negedge clk);
    rst = 1;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_mul_out", mul_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    rst = 0;
    issue(32'd32768, 32'd25000);
    wait_idle();

    // Random operands with random back-pressure.
    rnd_rdy = 1;
    for (int k = 0; k < 40; k++) begin
      x = ($urandom_range(0, 2) == 0) ? $urandom : $urandom_range(0, 1 << 18);
      y = ($urandom_range(0, 2) == 0) ? $urandom : $urandom_range(0, 1 << 22);
      x[31] = $urandom_range(0, 1);
      y[31] = $urandom_range(0, 1);
      issue(x, y);
    end
    rnd_rdy = 0;
    @(posedge clk); #1 out_ready = 1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
